// File: rtl/tx_axis_arbiter_if.sv
// AXI-Stream bundle for the TX arbiter: NUM_PORTS packed request streams in,
// one merged stream out toward the MAC.
interface tx_axis_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [NUM_PORTS-1:0]            s_axis_tvalid;
    logic [NUM_PORTS-1:0]            s_axis_tlast;
    logic [NUM_PORTS-1:0]            s_axis_trdy;
    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
    logic                            m_axis_tvalid;
    logic                            m_axis_tlast;
    logic                            m_axis_trdy;

    // slave: the arbiter's view (it receives the request streams)
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_trdy,
        output s_axis_trdy, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_trdy,
        input  s_axis_trdy, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/tx_axis_arbiter.sv
// Packet-level round-robin arbiter sharing the TX MAC stream input between
// NUM_PORTS masters; a grant is held from first beat through tlast.
module tx_axis_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int PRIO_PORT0 = 0,
    parameter int IDX_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NUM_PORTS-1:0] i_port_en,
    tx_axis_arbiter_if.slave     axis,
    output logic [IDX_WIDTH-1:0] o_grant_idx,
    output logic                 o_busy
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_WIDTH-1:0] grant_idx, grant_nxt;
    logic [IDX_WIDTH-1:0] last_grant, last_grant_nxt;
    logic [IDX_WIDTH-1:0] rr_idx;
    logic [NUM_PORTS-1:0] req;
    logic                 sel_valid, sel_last;

    // The enable mask only matters at arbitration; a locked packet ignores it.
    assign req = axis.s_axis_tvalid & i_port_en;

    always_comb begin : rr_search
        int unsigned          cand;
        logic [IDX_WIDTH-1:0] cand_idx;
        logic                 found;
        rr_idx   = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = 32'(last_grant) + k;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            cand_idx = IDX_WIDTH'(cand);
            if (!found && req[cand_idx]) begin
                found  = 1'b1;
                rr_idx = cand_idx;
            end
        end
        if (PRIO_PORT0 != 0 && req[0]) rr_idx = '0;
    end

    assign sel_valid = axis.s_axis_tvalid[grant_idx];
    assign sel_last  = axis.s_axis_tlast[grant_idx];

    always_comb begin
        state_nxt          = state;
        grant_nxt          = grant_idx;
        last_grant_nxt     = last_grant;
        axis.s_axis_trdy   = '0;
        axis.m_axis_tdata  = '0;
        axis.m_axis_tkeep  = '0;
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tlast  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = rr_idx;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                axis.m_axis_tdata           = axis.s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                axis.m_axis_tkeep           = axis.s_axis_tkeep[grant_idx*KEEP_WIDTH +: KEEP_WIDTH];
                axis.m_axis_tvalid          = sel_valid;
                axis.m_axis_tlast           = sel_last;
                axis.s_axis_trdy[grant_idx] = axis.m_axis_trdy;
                if (sel_valid && axis.m_axis_trdy && sel_last) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant_idx;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_WIDTH'(NUM_PORTS - 1);
        end else begin
            state      <= state_nxt;
            grant_idx  <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    assign o_busy      = (state == LOCKED);
    assign o_grant_idx = grant_idx;

endmodule
